secure_bank_ctrl: RTL and testbench

SECURE_BANK_CTRL -- requirements
Module: secure_bank_ctrl

---
 rtl/secure_bank_if.sv | 36 +++
 rtl/secure_bank_ctrl.sv | 125 ++++++++++++
 tb/tb_secure_bank_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/secure_bank_if.sv
// Requester-facing bus of the secure bank controller: two write requesters,
// the lock pulse, and the bank/lock/busy status returned to them.
interface secure_bank_if #(
    parameter int NBANKS = 4,
    parameter int DW     = 2,
    parameter int BW     = 3
);
    logic                 req_a;
    logic                 req_b;
    logic [BW-1:0]        bank_a;
    logic [BW-1:0]        bank_b;
    logic                 bcast_a;
    logic                 bcast_b;
    logic [DW-1:0]        wdata_a;
    logic [DW-1:0]        wdata_b;
    logic                 lock_set;
    logic                 ack_a;
    logic                 ack_b;
    logic                 err_a;
    logic                 err_b;
    logic [NBANKS*DW-1:0] bank_q;
    logic                 locked;
    logic                 busy;

    modport master (
        output req_a, req_b, bank_a, bank_b, bcast_a, bcast_b,
               wdata_a, wdata_b, lock_set,
        input  ack_a, ack_b, err_a, err_b, bank_q, locked, busy
    );

    modport slave (
        input  req_a, req_b, bank_a, bank_b, bcast_a, bcast_b,
               wdata_a, wdata_b, lock_set,
        output ack_a, ack_b, err_a, err_b, bank_q, locked, busy
    );
endinterface

// File: rtl/secure_bank_ctrl.sv
// Secure multi-bank register controller: round-robin arbitration between two
// requesters, sticky global lock, and all-or-nothing broadcast writes.
module secure_bank_ctrl #(
    parameter int NBANKS = 4,
    parameter int DW     = 2,
    parameter int BW     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    secure_bank_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [BW:0]   LP_NB   = (BW+1)'(NBANKS);
    localparam logic [BW-1:0] LP_LAST = BW'(NBANKS - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_ptr;
    logic                 r_gnt_b;
    logic                 r_bcast;
    logic                 r_locked;
    logic                 r_ack_a;
    logic                 r_ack_b;
    logic                 r_err_a;
    logic                 r_err_b;
    logic [BW-1:0]        r_cnt;
    logic [DW-1:0]        r_wdata;
    logic [NBANKS*DW-1:0] r_banks;

    logic                 w_any;
    logic                 w_gnt_b;
    logic                 w_sel_bcast;
    logic [BW-1:0]        w_sel_bank;
    logic [DW-1:0]        w_sel_wdata;
    logic                 w_reject;
    logic                 w_last;
    logic                 w_busy;
    logic                 w_wr_en;
    logic                 w_resp_gnt_b;
    logic                 w_resp_err;
    logic                 w_to_resp;

    // r_ptr = 1 means B owns the tie-break
    assign w_any       = bus.req_a | bus.req_b;
    assign w_gnt_b     = bus.req_b & (~bus.req_a | r_ptr);
    assign w_sel_bank  = w_gnt_b ? bus.bank_b  : bus.bank_a;
    assign w_sel_bcast = w_gnt_b ? bus.bcast_b : bus.bcast_a;
    assign w_sel_wdata = w_gnt_b ? bus.wdata_b : bus.wdata_a;
    assign w_reject    = r_locked | bus.lock_set |
                         (~w_sel_bcast & ({1'b0, w_sel_bank} >= LP_NB));
    assign w_last      = ~r_bcast | (r_cnt == LP_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = w_reject ? RESP : WRITE;
            WRITE:   if (w_last) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The decision is taken at grant only; reaching RESP via WRITE means accepted
    always_comb begin
        w_busy       = (r_state != IDLE);
        w_wr_en      = (r_state == WRITE);
        w_to_resp    = (w_next == RESP);
        w_resp_gnt_b = (r_state == IDLE) ? w_gnt_b : r_gnt_b;
        w_resp_err   = (r_state == IDLE) & w_reject;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr    <= 1'b0;
            r_gnt_b  <= 1'b0;
            r_bcast  <= 1'b0;
            r_locked <= 1'b0;
            r_ack_a  <= 1'b0;
            r_ack_b  <= 1'b0;
            r_err_a  <= 1'b0;
            r_err_b  <= 1'b0;
            r_cnt    <= '0;
            r_wdata  <= '0;
            r_banks  <= '0;
        end else begin
            r_locked <= r_locked | bus.lock_set;
            r_ack_a  <= w_to_resp & ~w_resp_gnt_b;
            r_ack_b  <= w_to_resp &  w_resp_gnt_b;
            r_err_a  <= w_to_resp & ~w_resp_gnt_b & w_resp_err;
            r_err_b  <= w_to_resp &  w_resp_gnt_b & w_resp_err;
            if (r_state == IDLE && w_any) begin
                r_ptr   <= ~w_gnt_b;
                r_gnt_b <= w_gnt_b;
                r_bcast <= w_sel_bcast;
                r_wdata <= w_sel_wdata;
                r_cnt   <= w_sel_bcast ? '0 : w_sel_bank;
            end else if (w_wr_en && !w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_wr_en) begin
                for (int i = 0; i < NBANKS; i++) begin
                    if (r_cnt == BW'(i)) r_banks[i*DW +: DW] <= r_wdata;
                end
            end
        end
    end

    assign bus.ack_a  = r_ack_a;
    assign bus.ack_b  = r_ack_b;
    assign bus.err_a  = r_err_a;
    assign bus.err_b  = r_err_b;
    assign bus.bank_q = r_banks;
    assign bus.locked = r_locked;
    assign bus.busy   = w_busy;
endmodule

// File: tb/tb_secure_bank_ctrl.sv
// Directed self-checking bench for secure_bank_ctrl at NBANKS=4, DW=2, BW=3.
module tb_secure_bank_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    secure_bank_if #(.NBANKS(4), .DW(2), .BW(3)) bus ();

    secure_bank_ctrl #(.NBANKS(4), .DW(2), .BW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_a = 0; bus.req_b = 0; bus.bank_a = 0; bus.bank_b = 0;
        bus.bcast_a = 0; bus.bcast_b = 0; bus.wdata_a = 0; bus.wdata_b = 0;
        bus.lock_set = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        bus.lock_set = 1;
        tick();
        tick();
        check("rst_bank_q", bus.bank_q, 8'h00);
        check("rst_locked_prio", bus.locked, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_acks", {bus.ack_a, bus.ack_b, bus.err_a, bus.err_b}, 4'b0000);
        bus.lock_set = 0;
        rst_n = 1;
        tick();

        // single write A: bank 2 <= 11
        bus.req_a = 1; bus.bank_a = 2; bus.wdata_a = 2'b11;
        tick();
        check("sw_busy_t", bus.busy, 1);
        check("sw_bank_t", bus.bank_q, 8'h00);
        check("sw_ack_t", bus.ack_a, 0);
        tick();
        check("sw_bank_t1", bus.bank_q, 8'h30);
        check("sw_ack_a", {bus.ack_a, bus.err_a, bus.ack_b, bus.err_b}, 4'b1000);
        check("sw_busy_t1", bus.busy, 1);
        bus.req_a = 0;
        tick();
        check("sw_busy_end", bus.busy, 0);
        check("sw_ack_end", bus.ack_a, 0);

        // broadcast B: 01 to all banks
        bus.req_b = 1; bus.bcast_b = 1; bus.wdata_b = 2'b01; bus.bank_b = 6;
        tick();
        check("bc_t", bus.bank_q, 8'h30);
        tick();
        check("bc_b0", bus.bank_q, 8'h31);
        tick();
        check("bc_b1", bus.bank_q, 8'h35);
        tick();
        check("bc_b2", bus.bank_q, 8'h15);
        check("bc_noack_early", bus.ack_b, 0);
        tick();
        check("bc_b3", bus.bank_q, 8'h55);
        check("bc_ack_b", {bus.ack_a, bus.err_a, bus.ack_b, bus.err_b}, 4'b0010);
        bus.req_b = 0; bus.bcast_b = 0;
        tick();
        check("bc_idle", bus.busy, 0);

        // lock uniformity: broadcast 10 from A, lock pulsed in 2nd WRITE cycle
        bus.req_a = 1; bus.bcast_a = 1; bus.wdata_a = 2'b10;
        tick();
        tick();
        bus.lock_set = 1;
        tick();
        bus.lock_set = 0;
        check("lk_locked_mid", bus.locked, 1);
        check("lk_bank_mid", bus.bank_q, 8'h5A);
        tick();
        tick();
        check("lk_bank_all", bus.bank_q, 8'hAA);
        check("lk_ack", {bus.ack_a, bus.err_a, bus.ack_b, bus.err_b}, 4'b1000);
        check("lk_locked", bus.locked, 1);
        bus.req_a = 0; bus.bcast_a = 0;
        tick();

        // follow-up while locked: rejected one cycle after grant
        bus.req_a = 1; bus.bank_a = 0; bus.wdata_a = 2'b01;
        tick();
        check("lk_rej_ack", {bus.ack_a, bus.err_a, bus.ack_b, bus.err_b}, 4'b1100);
        check("lk_rej_bank", bus.bank_q, 8'hAA);
        bus.req_a = 0;
        tick();
        check("lk_rej_idle", bus.busy, 0);

        // out-of-range bank
        do_reset();
        check("rst2_locked", bus.locked, 0);
        check("rst2_bank", bus.bank_q, 8'h00);
        bus.req_a = 1; bus.bank_a = 5; bus.wdata_a = 2'b11;
        tick();
        check("oor_ack", {bus.ack_a, bus.err_a, bus.ack_b, bus.err_b}, 4'b1100);
        check("oor_bank", bus.bank_q, 8'h00);
        bus.req_a = 0;
        tick();
        tick();
        check("oor_bank_after", bus.bank_q, 8'h00);

        // lock_set in the grant cycle (pointer now B)
        bus.req_b = 1; bus.bank_b = 1; bus.wdata_b = 2'b11; bus.lock_set = 1;
        tick();
        bus.lock_set = 0;
        check("lsg_ack", {bus.ack_a, bus.err_a, bus.ack_b, bus.err_b}, 4'b0011);
        check("lsg_bank", bus.bank_q, 8'h00);
        check("lsg_locked", bus.locked, 1);
        bus.req_b = 0;
        tick();

        // reset in the middle of a broadcast
        do_reset();
        bus.req_a = 1; bus.bcast_a = 1; bus.wdata_a = 2'b11;
        tick();
        tick();
        check("mr_bank0", bus.bank_q, 8'h03);
        rst_n = 0;
        bus.req_a = 0; bus.bcast_a = 0;
        tick();
        check("mr_bank", bus.bank_q, 8'h00);
        check("mr_locked", bus.locked, 0);
        check("mr_busy", bus.busy, 0);
        check("mr_ack", {bus.ack_a, bus.ack_b}, 2'b00);
        rst_n = 1;
        tick();
        tick();
        check("mr_ack_after", {bus.ack_a, bus.ack_b, bus.busy}, 3'b000);
        check("mr_bank_after", bus.bank_q, 8'h00);

        // arbitration: both requesting from reset
        rst_n = 0;
        bus.req_a = 1; bus.bank_a = 0; bus.wdata_a = 2'b01;
        bus.req_b = 1; bus.bank_b = 1; bus.wdata_b = 2'b10;
        tick();
        tick();
        rst_n = 1;
        tick();
        check("arb1_noack", {bus.ack_a, bus.ack_b}, 2'b00);
        tick();
        check("arb1_a", {bus.ack_a, bus.ack_b}, 2'b10);
        check("arb1_bank", bus.bank_q, 8'h01);
        bus.req_a = 0;
        tick();
        tick();
        check("arb2_noack", {bus.ack_a, bus.ack_b}, 2'b00);
        tick();
        check("arb2_b", {bus.ack_a, bus.ack_b}, 2'b01);
        check("arb2_bank", bus.bank_q, 8'h09);
        bus.req_b = 0;
        tick();
        bus.req_a = 1; bus.bank_a = 3; bus.wdata_a = 2'b11;
        bus.req_b = 1; bus.bank_b = 2; bus.wdata_b = 2'b01;
        tick();
        tick();
        check("arb3_a", {bus.ack_a, bus.ack_b}, 2'b10);
        check("arb3_bank", bus.bank_q, 8'hC9);
        bus.req_a = 0; bus.req_b = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
